// File: rtl/qspi_arb_pkg.sv
// Shared types and safe pad levels for the QSPI pad arbiter.
package qspi_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN  = 2'd1,
      GAP  = 2'd2
   } arb_state_e;

   localparam logic              SAFE_CS_N = 1'b1;
   localparam logic              SAFE_CLK  = 1'b0;
   localparam int                MAX_IO    = 32;
   localparam logic [MAX_IO-1:0] SAFE_OE_N = {MAX_IO{1'b1}};

   // Width of a down-counter holding 0..n, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/qspi_bus_arbiter_if.sv
// Bus bundle between the two pin-level QSPI masters, the arbiter and the flash pads.
interface qspi_bus_arbiter_if #(
   parameter int NUM_IO = 4
);
   logic [1:0]          req_i;
   logic [1:0]          gnt_o;
   logic [1:0]          m_sck_i;
   logic [1:0]          m_cs_ni;
   logic [2*NUM_IO-1:0] m_io_i;
   logic [2*NUM_IO-1:0] m_io_oe_ni;
   logic [2*NUM_IO-1:0] m_io_o;
   logic                flash_clk_o;
   logic                flash_cs_no;
   logic [NUM_IO-1:0]   flash_io_o;
   logic [NUM_IO-1:0]   flash_io_oe_no;
   logic [NUM_IO-1:0]   flash_io_i;
   logic                owner_o;
   logic                busy_o;

   // Arbiter side
   modport slave (
      input  req_i, m_sck_i, m_cs_ni, m_io_i, m_io_oe_ni, flash_io_i,
      output gnt_o, m_io_o, flash_clk_o, flash_cs_no, flash_io_o, flash_io_oe_no,
             owner_o, busy_o
   );

   // Masters and pad side
   modport master (
      output req_i, m_sck_i, m_cs_ni, m_io_i, m_io_oe_ni, flash_io_i,
      input  gnt_o, m_io_o, flash_clk_o, flash_cs_no, flash_io_o, flash_io_oe_no,
             owner_o, busy_o
   );
endinterface

// File: rtl/qspi_pin_mux.sv
// Combinational pad selection: owner's pins to the pads, or safe pad levels,
// plus routing of pad read data back to the owner only.
module qspi_pin_mux
   import qspi_arb_pkg::*;
#(
   parameter int NUM_IO = 4
) (
   input  logic                i_drive,
   input  logic                i_owner,
   input  logic [1:0]          i_m_sck,
   input  logic [1:0]          i_m_cs_n,
   input  logic [2*NUM_IO-1:0] i_m_io,
   input  logic [2*NUM_IO-1:0] i_m_io_oe_n,
   input  logic [NUM_IO-1:0]   i_flash_io,
   output logic [2*NUM_IO-1:0] o_m_io,
   output logic                o_flash_clk,
   output logic                o_flash_cs_n,
   output logic [NUM_IO-1:0]   o_flash_io,
   output logic [NUM_IO-1:0]   o_flash_io_oe_n
);

   // Owner drives the pads with zero latency; the non-owner is fully gated off.
   always_comb begin
      o_flash_clk     = SAFE_CLK;
      o_flash_cs_n    = SAFE_CS_N;
      o_flash_io      = {NUM_IO{1'b0}};
      o_flash_io_oe_n = SAFE_OE_N[NUM_IO-1:0];
      o_m_io          = {(2*NUM_IO){1'b0}};
      if (i_drive) begin
         if (i_owner) begin
            o_flash_clk               = i_m_sck[1];
            o_flash_cs_n              = i_m_cs_n[1];
            o_flash_io                = i_m_io[NUM_IO +: NUM_IO];
            o_flash_io_oe_n           = i_m_io_oe_n[NUM_IO +: NUM_IO];
            o_m_io[NUM_IO +: NUM_IO]  = i_flash_io;
         end else begin
            o_flash_clk               = i_m_sck[0];
            o_flash_cs_n              = i_m_cs_n[0];
            o_flash_io                = i_m_io[0 +: NUM_IO];
            o_flash_io_oe_n           = i_m_io_oe_n[0 +: NUM_IO];
            o_m_io[0 +: NUM_IO]       = i_flash_io;
         end
      end else begin
         o_flash_clk     = SAFE_CLK;
         o_flash_cs_n    = SAFE_CS_N;
         o_flash_io      = {NUM_IO{1'b0}};
         o_flash_io_oe_n = SAFE_OE_N[NUM_IO-1:0];
         o_m_io          = {(2*NUM_IO){1'b0}};
      end
   end

endmodule

// File: rtl/qspi_bus_arbiter.sv
// Two-master QSPI pad arbiter: whole-transaction grants, round-robin on ties,
// never revokes while the owner holds cs_n low, forced idle gap between owners.
module qspi_bus_arbiter
   import qspi_arb_pkg::*;
#(
   parameter int NUM_IO     = 4,
   parameter int GAP_CYCLES = 2,
   parameter int GAP_W      = cnt_width(GAP_CYCLES)
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   qspi_bus_arbiter_if.slave bus
);

   // The IDLE cycle that follows GAP is itself part of the idle gap, so GAP
   // is left as soon as the decremented count reaches zero.
   localparam logic [GAP_W-1:0] GAP_LOAD =
      (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : {GAP_W{1'b0}};

   arb_state_e       r_state;
   arb_state_e       w_state_nxt;
   logic [1:0]       r_gnt;
   logic [1:0]       w_gnt_nxt;
   logic             r_owner;
   logic             w_owner_nxt;
   logic             r_last;
   logic             w_last_nxt;
   logic             r_busy;
   logic             w_busy_nxt;
   logic [GAP_W-1:0] r_gap_cnt;
   logic [GAP_W-1:0] w_gap_nxt;
   logic [GAP_W-1:0] w_gap_dec;
   logic             w_any_req;
   logic             w_winner;
   logic             w_release;
   logic             w_drive;

   assign w_any_req = |bus.req_i;
   assign w_winner  = (bus.req_i == 2'b11) ? ~r_last : bus.req_i[1];
   assign w_release = ~bus.req_i[r_owner] & bus.m_cs_ni[r_owner];
   assign w_gap_dec = (r_gap_cnt != {GAP_W{1'b0}}) ? (r_gap_cnt - GAP_W'(1'b1))
                                                   : {GAP_W{1'b0}};
   assign w_drive   = (r_state == OWN);

   // State, grant, owner, round-robin pointer and gap counter registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state   <= IDLE;
         r_gnt     <= 2'b00;
         r_owner   <= 1'b0;
         r_last    <= 1'b1;
         r_busy    <= 1'b0;
         r_gap_cnt <= {GAP_W{1'b0}};
      end else begin
         r_state   <= w_state_nxt;
         r_gnt     <= w_gnt_nxt;
         r_owner   <= w_owner_nxt;
         r_last    <= w_last_nxt;
         r_busy    <= w_busy_nxt;
         r_gap_cnt <= w_gap_nxt;
      end
   end

   // Next state, gap counter and round-robin pointer.
   always_comb begin
      w_state_nxt = r_state;
      w_gap_nxt   = r_gap_cnt;
      w_last_nxt  = r_last;
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_state_nxt = OWN;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         OWN: begin
            if (w_release) begin
               w_last_nxt = r_owner;
               if (GAP_CYCLES == 0) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = GAP;
                  w_gap_nxt   = GAP_LOAD;
               end
            end else begin
               w_state_nxt = OWN;
            end
         end
         GAP: begin
            w_gap_nxt = w_gap_dec;
            if (w_gap_dec == {GAP_W{1'b0}}) begin
               w_state_nxt = IDLE;
            end else begin
               w_state_nxt = GAP;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_gap_nxt   = {GAP_W{1'b0}};
         end
      endcase
   end

   // Next values of the registered grant, owner and busy outputs.
   always_comb begin
      w_gnt_nxt   = r_gnt;
      w_owner_nxt = r_owner;
      w_busy_nxt  = (w_state_nxt != IDLE);
      case (r_state)
         IDLE: begin
            if (w_any_req) begin
               w_owner_nxt = w_winner;
               w_gnt_nxt   = w_winner ? 2'b10 : 2'b01;
            end else begin
               w_gnt_nxt   = 2'b00;
            end
         end
         OWN: begin
            if (w_release) begin
               w_gnt_nxt = 2'b00;
            end else begin
               w_gnt_nxt = r_gnt;
            end
         end
         GAP:     w_gnt_nxt = 2'b00;
         default: w_gnt_nxt = 2'b00;
      endcase
   end

   assign bus.gnt_o   = r_gnt;
   assign bus.owner_o = r_owner;
   assign bus.busy_o  = r_busy;

   qspi_pin_mux #(
      .NUM_IO (NUM_IO)
   ) u_pin_mux (
      .i_drive         (w_drive),
      .i_owner         (r_owner),
      .i_m_sck         (bus.m_sck_i),
      .i_m_cs_n        (bus.m_cs_ni),
      .i_m_io          (bus.m_io_i),
      .i_m_io_oe_n     (bus.m_io_oe_ni),
      .i_flash_io      (bus.flash_io_i),
      .o_m_io          (bus.m_io_o),
      .o_flash_clk     (bus.flash_clk_o),
      .o_flash_cs_n    (bus.flash_cs_no),
      .o_flash_io      (bus.flash_io_o),
      .o_flash_io_oe_n (bus.flash_io_oe_no)
   );

endmodule
